if_id_skid_stage: RTL

- Pipeline boundary between the instruction-fetch stage (PC and instruction memory) and the decode stage.
- Registers the fetched 16-bit instruction with its PC and PC+increment.
- Absorbs decode back-pressure in a 2-entry skid buffer and discards wrong-path instructions on a taken branch (pcSrc).
- Decode always sees a registered, valid-qualified instruction, or a NOP bubble.

---
 rtl/if_id_skid_stage.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/if_id_skid_stage.sv
// -----------------------------------------------------------------------------
// if_id_skid_stage
//
// Pipeline boundary between instruction fetch and decode. Each fetched
// instruction is captured together with its PC and PC+PC_INC into a 2-entry
// skid buffer (head + skid). Decode always sees registered outputs: either a
// valid head entry or a NOP bubble. A taken branch (pcSrc) flushes every
// buffered wrong-path entry and drops any instruction offered that cycle.
//
// Ports:
//   inp_clk         in   system clock, rising edge
//   inp_rst_n       in   asynchronous active-low reset
//   if_valid        in   fetch offers an instruction this cycle
//   if_instruction  in   fetched instruction   [DATA_W]
//   if_pc           in   address of the fetched instruction [ADDR_W]
//   if_ready        out  stage can accept (registered)
//   pcSrc           in   taken branch / redirect, flushes the stage
//   id_valid        out  head entry valid toward decode
//   id_instruction  out  head instruction, NOP_INSTR when id_valid=0
//   id_pc           out  head PC
//   id_pc_next      out  head PC + PC_INC (mod 2^ADDR_W)
//   id_ready        in   decode consumes the head this cycle
//
// Optional feature (macro IF_ID_PERF_CNT_EN):
//   perf_issued     out  saturating count of instructions handed to decode
//   perf_flushed    out  saturating count of instructions dropped by flushes
// -----------------------------------------------------------------------------
module if_id_skid_stage #(
    parameter int              DATA_W    = 16,
    parameter int              ADDR_W    = 16,
    parameter int              PC_INC    = 1,
    parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
    input  logic              inp_clk,
    input  logic              inp_rst_n,
    input  logic              if_valid,
    input  logic [DATA_W-1:0] if_instruction,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              if_ready,
    input  logic              pcSrc,
    output logic              id_valid,
    output logic [DATA_W-1:0] id_instruction,
    output logic [ADDR_W-1:0] id_pc,
    output logic [ADDR_W-1:0] id_pc_next,
    input  logic              id_ready
`ifdef IF_ID_PERF_CNT_EN
    ,
    output logic [31:0]       perf_issued,
    output logic [31:0]       perf_flushed
`endif
);

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] pc_next;
    } entry_t;

    localparam logic [1:0] CNT_EMPTY = 2'd0;
    localparam logic [1:0] CNT_ONE   = 2'd1;
    localparam logic [1:0] CNT_FULL  = 2'd2;

    entry_t     head_q, head_d;
    entry_t     skid_q, skid_d;
    logic [1:0] count_q, count_d;
    logic       if_ready_q, if_ready_d;

    logic       push;
    logic       pop;
    entry_t     new_entry;

    // Outputs come straight from registers; no input reaches them combinationally.
    assign id_valid       = (count_q != CNT_EMPTY);
    assign id_instruction = id_valid ? head_q.instr : NOP_INSTR;
    assign id_pc          = head_q.pc;
    assign id_pc_next     = head_q.pc_next;
    assign if_ready       = if_ready_q;

    assign push = if_valid & if_ready_q;
    assign pop  = id_valid & id_ready;

    // pc_next is formed at capture so decode never waits on the adder.
    assign new_entry.instr   = if_instruction;
    assign new_entry.pc      = if_pc;
    assign new_entry.pc_next = if_pc + ADDR_W'(PC_INC);

    always_comb begin
        head_d  = head_q;
        skid_d  = skid_q;
        count_d = count_q;

        if (pcSrc) begin
            // Flush wins over everything; a same-cycle pop was still taken by decode.
            count_d = CNT_EMPTY;
        end else begin
            unique case (count_q)
                CNT_EMPTY: begin
                    if (push) begin
                        head_d  = new_entry;
                        count_d = CNT_ONE;
                    end
                end
                CNT_ONE: begin
                    if (push && pop) begin
                        head_d = new_entry;
                    end else if (push) begin
                        skid_d  = new_entry;
                        count_d = CNT_FULL;
                    end else if (pop) begin
                        count_d = CNT_EMPTY;
                    end
                end
                CNT_FULL: begin
                    // if_ready is low here, so only a pop can happen.
                    if (pop) begin
                        head_d  = skid_q;
                        count_d = CNT_ONE;
                    end
                end
                default: begin
                    count_d = CNT_EMPTY;
                end
            endcase
        end

        if_ready_d = (count_d != CNT_FULL);
    end

    always_ff @(posedge inp_clk or negedge inp_rst_n) begin
        if (!inp_rst_n) begin
            head_q     <= '0;
            skid_q     <= '0;
            count_q    <= CNT_EMPTY;
            if_ready_q <= 1'b1;
        end else begin
            head_q     <= head_d;
            skid_q     <= skid_d;
            count_q    <= count_d;
            if_ready_q <= if_ready_d;
        end
    end

`ifdef IF_ID_PERF_CNT_EN
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {31'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    logic [31:0] perf_issued_q, perf_issued_d;
    logic [31:0] perf_flushed_q, perf_flushed_d;
    logic [1:0]  flush_drop;

    // Dropped = buffered entries not consumed this cycle, plus the instruction
    // fetch offered on the wrong path (if_ready is low when FULL, but that
    // offered instruction is still lost to the redirect).
    assign flush_drop = count_q - {1'b0, pop} + {1'b0, if_valid};

    always_comb begin
        perf_issued_d  = pop   ? sat_add(perf_issued_q, 2'd1)        : perf_issued_q;
        perf_flushed_d = pcSrc ? sat_add(perf_flushed_q, flush_drop) : perf_flushed_q;
    end

    always_ff @(posedge inp_clk or negedge inp_rst_n) begin
        if (!inp_rst_n) begin
            perf_issued_q  <= '0;
            perf_flushed_q <= '0;
        end else begin
            perf_issued_q  <= perf_issued_d;
            perf_flushed_q <= perf_flushed_d;
        end
    end

    assign perf_issued  = perf_issued_q;
    assign perf_flushed = perf_flushed_q;
`endif

endmodule
